// File: rtl/scope_vga_pkg.sv
// Shared VGA timing constants, pixel/sample types and trace helpers for the scope renderer.
package scope_vga_pkg;

  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 751;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 491;

  typedef logic [11:0] rgb444_t;
  typedef logic [9:0]  sample_t;

  localparam rgb444_t GRID_COLOR = 12'h333;

  function automatic sample_t clamp_row(input sample_t s, input sample_t max_row);
    return (s > max_row) ? max_row : s;
  endfunction

  // True when row y lies on the vertical segment joining two adjacent samples.
  function automatic logic seg_lit(input sample_t a, input sample_t b, input sample_t y);
    sample_t lo;
    sample_t hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (y >= lo) && (y <= hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider plus horizontal/vertical raster counters, raw syncs and active flag.
module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 4
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  output logic       o_pix_tick,
  output logic [9:0] o_h_cnt,
  output logic [9:0] o_v_cnt,
  output logic       o_hsync_raw,
  output logic       o_vsync_raw,
  output logic       o_active
);

  localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_FIN  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_FIN  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             w_pix_tick;

  assign w_pix_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_div <= w_pix_tick ? '0 : r_div + 1'b1;
      if (w_pix_tick) begin
        if (r_h_cnt == H_LAST) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  assign o_pix_tick  = w_pix_tick;
  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_hsync_raw = !((r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_FIN));
  assign o_vsync_raw = !((r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_FIN));
  assign o_active    = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

endmodule

// File: rtl/scope_trace_renderer.sv
// Draws two snapshotted scope channels as connected traces on 640x480@60 VGA.
// Define SCOPE_GRATICULE_EN to add a grey grid behind the traces.
module scope_trace_renderer import scope_vga_pkg::*; #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = H_SYNC_START - 640,
  parameter int unsigned H_SYNC    = H_SYNC_END - H_SYNC_START + 1,
  parameter int unsigned H_BP      = H_TOTAL - H_SYNC_END - 1,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = V_SYNC_START - 480,
  parameter int unsigned V_SYNC    = V_SYNC_END - V_SYNC_START + 1,
  parameter int unsigned V_BP      = V_TOTAL - V_SYNC_END - 1,
  parameter int unsigned PIX_DIV   = 4,
  parameter rgb444_t     CH1_COLOR = 12'hFF0,
  parameter rgb444_t     CH2_COLOR = 12'h0FF
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  input  logic [639:0][9:0] ch1,
  input  logic [639:0][9:0] ch2,
  input  logic              freeze,
  output logic              hsync,
  output logic              vsync,
  output logic [11:0]       rgb,
  output logic              frame_start
);

  localparam sample_t    ROW_MAX   = sample_t'(V_ACTIVE - 1);
  localparam logic [9:0] SNAP_LINE = 10'(V_ACTIVE);

  logic       w_pix_tick;
  logic [9:0] w_h;
  logic [9:0] w_v;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_active;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .PIX_DIV  (PIX_DIV)
  ) u_timing (
    .clk_100MHz  (clk_100MHz),
    .rst_n       (rst_n),
    .o_pix_tick  (w_pix_tick),
    .o_h_cnt     (w_h),
    .o_v_cnt     (w_v),
    .o_hsync_raw (w_hs_raw),
    .o_vsync_raw (w_vs_raw),
    .o_active    (w_active)
  );

  // Snapshot taken at the start of vblank so the visible frame never tears.
  sample_t r_snap1 [640];
  sample_t r_snap2 [640];
  logic    r_frame_start;
  logic    w_snap_evt;

  assign w_snap_evt = w_pix_tick && (w_h == 10'd0) && (w_v == SNAP_LINE);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 640; i++) begin
        r_snap1[i] <= ROW_MAX;
        r_snap2[i] <= ROW_MAX;
      end
    end else if (w_snap_evt && !freeze) begin
      for (int i = 0; i < 640; i++) begin
        r_snap1[i] <= clamp_row(ch1[i], ROW_MAX);
        r_snap2[i] <= clamp_row(ch2[i], ROW_MAX);
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap_evt;
    end
  end

  // Stage 1: fetch current and previous column samples for both channels.
  logic [9:0] w_col;
  sample_t    w_cur1;
  sample_t    w_cur2;
  sample_t    w_prev1;
  sample_t    w_prev2;

  sample_t r_s1_cur1;
  sample_t r_s1_prev1;
  sample_t r_s1_cur2;
  sample_t r_s1_prev2;
  sample_t r_s1_y;
  logic    r_s1_act;
  logic    r_s1_hs;
  logic    r_s1_vs;

  assign w_col   = (w_h < 10'd640) ? w_h : 10'd0;
  assign w_cur1  = r_snap1[w_col];
  assign w_cur2  = r_snap2[w_col];
  assign w_prev1 = (w_h == 10'd0) ? r_snap1[0] : r_s1_cur1;
  assign w_prev2 = (w_h == 10'd0) ? r_snap2[0] : r_s1_cur2;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_cur1  <= '0;
      r_s1_prev1 <= '0;
      r_s1_cur2  <= '0;
      r_s1_prev2 <= '0;
      r_s1_y     <= '0;
      r_s1_act   <= 1'b0;
      r_s1_hs    <= 1'b1;
      r_s1_vs    <= 1'b1;
    end else if (w_pix_tick) begin
      r_s1_cur1  <= w_cur1;
      r_s1_prev1 <= w_prev1;
      r_s1_cur2  <= w_cur2;
      r_s1_prev2 <= w_prev2;
      r_s1_y     <= w_v;
      r_s1_act   <= w_active;
      r_s1_hs    <= w_hs_raw;
      r_s1_vs    <= w_vs_raw;
    end
  end

  // Stage 2: colour resolve; ch1 wins where both traces cover a pixel.
  rgb444_t w_bg;
  rgb444_t w_rgb_nxt;
  logic    w_lit1;
  logic    w_lit2;

  assign w_lit1 = seg_lit(r_s1_prev1, r_s1_cur1, r_s1_y);
  assign w_lit2 = seg_lit(r_s1_prev2, r_s1_cur2, r_s1_y);

`ifdef SCOPE_GRATICULE_EN
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  logic [9:0] r_s1_x;
  logic       w_grid;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_x <= '0;
    end else if (w_pix_tick) begin
      r_s1_x <= w_h;
    end
  end

  assign w_grid = (r_s1_x[5:0] == 6'd0) || ((r_s1_y % 10'd60) == 10'd0) ||
                  (r_s1_x == X_LAST) || (r_s1_y == ROW_MAX);
  assign w_bg   = w_grid ? GRID_COLOR : 12'h000;
`else
  assign w_bg = 12'h000;
`endif

  always_comb begin
    w_rgb_nxt = 12'h000;
    if (r_s1_act) begin
      if (w_lit1) begin
        w_rgb_nxt = CH1_COLOR;
      end else if (w_lit2) begin
        w_rgb_nxt = CH2_COLOR;
      end else begin
        w_rgb_nxt = w_bg;
      end
    end
  end

  rgb444_t r_rgb;
  logic    r_hs;
  logic    r_vs;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (w_pix_tick) begin
      r_rgb <= w_rgb_nxt;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Scoreboard bench for scope_trace_renderer on a reduced raster geometry.
module tb_scope_trace_renderer;

  localparam int HA = 32, HF = 2, HS = 4, HB = 2;
  localparam int VA = 24, VF = 2, VS = 2, VB = 2;
  localparam int PD = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * PD;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } px_t;

  localparam px_t IDLE = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [639:0][9:0] ch1;
  logic [639:0][9:0] ch2;
  logic              freeze;
  logic              hsync;
  logic              vsync;
  logic [11:0]       rgb;
  logic              frame_start;

  always #5 clk = ~clk;

  scope_trace_renderer #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .PIX_DIV  (PD)
  ) dut (
    .clk_100MHz  (clk),
    .rst_n       (rst_n),
    .ch1         (ch1),
    .ch2         (ch2),
    .freeze      (freeze),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  int  vectors = 0;
  int  miscompares = 0;
  int  edge_cnt;
  int  pos;
  int  m_snap1 [640];
  int  m_snap2 [640];
  px_t exp_q [$];
  bit  fs_q [$];
  px_t cur_px;
  bit  cur_fs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic bit on_seg(input int a, input int b, input int y);
    int lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (y >= lo) && (y <= hi);
  endfunction

  // Expected output for raster position p, straight from the drawing rules.
  function automatic px_t model_pixel(input int p);
    px_t r;
    int h, v, hp;
    h = p % HT;
    v = (p / HT) % VT;
    hp = (h == 0) ? 0 : h - 1;
    r.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    r.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    r.rgb = 12'h000;
    if (h < HA && v < VA) begin
      if (on_seg(m_snap1[h], m_snap1[hp], v))      r.rgb = 12'hFF0;
      else if (on_seg(m_snap2[h], m_snap2[hp], v)) r.rgb = 12'h0FF;
    end
    return r;
  endfunction

  // Reference model: one raster position per pixel period, pushed before the tick edge.
  initial begin : model
    int h, v;
    bit snap;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pos = 0;
        for (int i = 0; i < 640; i++) begin
          m_snap1[i] = VA - 1;
          m_snap2[i] = VA - 1;
        end
        exp_q.delete();
        fs_q.delete();
        exp_q.push_back(IDLE);
      end else if ((edge_cnt + 1) % PD == 0) begin
        h = pos % HT;
        v = (pos / HT) % VT;
        snap = (h == 0) && (v == VA);
        exp_q.push_back(model_pixel(pos));
        fs_q.push_back(snap);
        if (snap && !freeze) begin
          for (int i = 0; i < 640; i++) begin
            m_snap1[i] = (int'(ch1[i]) > VA - 1) ? VA - 1 : int'(ch1[i]);
            m_snap2[i] = (int'(ch2[i]) > VA - 1) ? VA - 1 : int'(ch2[i]);
          end
        end
        pos++;
      end
    end
  end

  // Monitor: pops on each pixel update, checks outputs hold on every clock.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_px = IDLE;
        cur_fs = 1'b0;
      end else if (edge_cnt > 0 && edge_cnt % PD == 0) begin
        if (exp_q.size() == 0 || fs_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_underflow t=%0t exp_q=%0d fs_q=%0d", $time, exp_q.size(),
                   fs_q.size());
        end else begin
          cur_px = exp_q.pop_front();
          cur_fs = fs_q.pop_front();
        end
      end else begin
        cur_fs = 1'b0;
      end
      vectors++;
      if ({hsync, vsync, rgb} !== {cur_px.hs, cur_px.vs, cur_px.rgb}) begin
        miscompares++;
        $display("FAIL pixel t=%0t got hs=%0b vs=%0b rgb=%03h want hs=%0b vs=%0b rgb=%03h",
                 $time, hsync, vsync, rgb, cur_px.hs, cur_px.vs, cur_px.rgb);
      end
      vectors++;
      if (frame_start !== cur_fs) begin
        miscompares++;
        $display("FAIL frame_start t=%0t got %0b want %0b", $time, frame_start, cur_fs);
      end
    end
  end

  // Raster timing landmarks after the first reset release.
  initial begin : timing_chk
    int n, t0;
    @(posedge rst_n);
    n = 0;
    do begin @(negedge clk); n++; end while (hsync && n < 4 * HT * PD);
    vectors++;
    if (hsync !== 1'b0 || edge_cnt != (HA + HF + 2) * PD) begin
      miscompares++;
      $display("FAIL hsync_first_fall got edge %0d want %0d", edge_cnt, (HA + HF + 2) * PD);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (vsync && n < 2 * FRAME);
    n = 0;
    while (vsync === 1'b0 && n < 2 * FRAME) begin n++; @(negedge clk); end
    vectors++;
    if (n != VS * HT * PD) begin
      miscompares++;
      $display("FAIL vsync_width got %0d clocks want %0d", n, VS * HT * PD);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 2 * FRAME);
    t0 = edge_cnt;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 2 * FRAME);
    vectors++;
    if (edge_cnt - t0 != FRAME) begin
      miscompares++;
      $display("FAIL frame_period got %0d clocks want %0d", edge_cnt - t0, FRAME);
    end
  end

  task automatic wait_fs();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < FRAME + 200);
    if (!frame_start) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_start_timeout got 0 want 1 within %0d clocks", FRAME + 200);
    end
  endtask

  task automatic fill(input int v1, input int v2);
    @(posedge clk); #1;
    for (int i = 0; i < 640; i++) begin
      ch1[i] = 10'(v1);
      ch2[i] = 10'(v2);
    end
  endtask

  initial begin : stim
    freeze = 1'b0;
    for (int i = 0; i < 640; i++) begin
      ch1[i] = 10'd20;
      ch2[i] = 10'd8;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_fs();

    fill(8, 8);
    ch1[11] = 10'd20;
    wait_fs();

    fill(15, 15);
    ch2[5] = 10'd600;
    wait_fs();

    @(posedge clk); #1 freeze = 1'b1;
    fill(5, 3);
    wait_fs();
    wait_fs();
    repeat (1000) @(posedge clk);
    #1 freeze = 1'b0;
    wait_fs();
    wait_fs();

    for (int it = 0; it < 4; it++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 640; i++) begin
        ch1[i] = 10'($urandom_range(0, 40));
        ch2[i] = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                             : 10'($urandom_range(0, 30));
      end
      freeze = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2000)) @(posedge clk);
      wait_fs();
    end

    // Asynchronous reset in the middle of a frame restarts the raster.
    repeat (2000) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    freeze = 1'b0;
    wait_fs();
    repeat (FRAME / 2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
